// File: rtl/lc3_execute.sv
// lc3_execute: LC3 execute stage with operand bypass, ALU, address adder and 1-cycle output registers.
// Optional LC3_EXEC_FLUSH_EN adds a flush input that bubbles the control outputs.
module lc3_execute #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable_execute,
`ifdef LC3_EXEC_FLUSH_EN
    input  logic          flush,
`endif
    input  logic [DW-1:0] IR,
    input  logic [DW-1:0] npc,
    input  logic [5:0]    E_Control,
    input  logic [1:0]    W_Control_in,
    input  logic          Mem_Control_in,
    input  logic [DW-1:0] VSR1,
    input  logic [DW-1:0] VSR2,
    input  logic          bypass_alu_1,
    input  logic          bypass_alu_2,
    input  logic          bypass_mem_1,
    input  logic          bypass_mem_2,
    input  logic [DW-1:0] Mem_Bypass_Val,
    output logic [DW-1:0] aluout,
    output logic [DW-1:0] pcout,
    output logic [1:0]    W_Control_out,
    output logic          Mem_Control_out,
    output logic [DW-1:0] M_Data,
    output logic [RW-1:0] dr,
    output logic [RW-1:0] sr1,
    output logic [RW-1:0] sr2,
    output logic [2:0]    NZP,
    output logic [DW-1:0] IR_Exec
);
    logic [DW-1:0] a, b, op2, alu, off, base, sum;
    logic [3:0]    op;
    logic [2:0]    nzp_d;
    logic          is_alu, bubble;
    always_comb begin
        op     = IR[15:12];
        a      = bypass_alu_1 ? aluout : bypass_mem_1 ? Mem_Bypass_Val : VSR1;
        b      = bypass_alu_2 ? aluout : bypass_mem_2 ? Mem_Bypass_Val : VSR2;
        op2    = E_Control[0] ? b : {{(DW-5){IR[4]}}, IR[4:0]};
        alu    = E_Control[5:4] == 2'b00 ? a + op2 :
                 E_Control[5:4] == 2'b01 ? a & op2 :
                 E_Control[5:4] == 2'b10 ? ~a : '0;
        off    = E_Control[3:2] == 2'b00 ? {{(DW-11){IR[10]}}, IR[10:0]} :
                 E_Control[3:2] == 2'b01 ? {{(DW-9){IR[8]}}, IR[8:0]} :
                 E_Control[3:2] == 2'b10 ? {{(DW-6){IR[5]}}, IR[5:0]} : '0;
        base   = E_Control[1] ? npc : a;
        sum    = off + base;
        is_alu = op == 4'b0001 || op == 4'b0101 || op == 4'b1001;
        nzp_d  = op == 4'b0000 ? IR[11:9] : op == 4'b1100 ? 3'b111 : 3'b000;
        sr1    = IR[8:6];
        // stores read their source register through the dr field
        sr2    = (op == 4'b0011 || op == 4'b0111 || op == 4'b1011) ? IR[11:9] : IR[2:0];
    end
`ifdef LC3_EXEC_FLUSH_EN
    assign bubble = flush;
`else
    assign bubble = 1'b0;
`endif
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            aluout          <= '0;
            pcout           <= '0;
            W_Control_out   <= '0;
            Mem_Control_out <= 1'b0;
            M_Data          <= '0;
            dr              <= '0;
            NZP             <= '0;
            IR_Exec         <= '0;
        end else if (enable_execute) begin
            aluout          <= is_alu ? alu : sum;
            pcout           <= sum;
            M_Data          <= b;
            dr              <= IR[11:9];
            W_Control_out   <= bubble ? 2'b00 : W_Control_in;
            Mem_Control_out <= bubble ? 1'b0 : Mem_Control_in;
            NZP             <= bubble ? 3'b000 : nzp_d;
            IR_Exec         <= bubble ? '0 : IR;
        end
    end
endmodule

// File: tb/tb_lc3_execute.sv
// tb_lc3_execute: directed vectors with a scoreboard queue checked by an independent monitor.
module tb_lc3_execute;
    logic        clock = 0, reset = 0, enable_execute = 0, flush = 0;
    logic [15:0] IR = 0, npc = 0, VSR1 = 0, VSR2 = 0, Mem_Bypass_Val = 0;
    logic [5:0]  E_Control = 0;
    logic [1:0]  W_Control_in = 0;
    logic        Mem_Control_in = 0;
    logic        bypass_alu_1 = 0, bypass_alu_2 = 0, bypass_mem_1 = 0, bypass_mem_2 = 0;
    logic [15:0] aluout, pcout, M_Data, IR_Exec;
    logic [1:0]  W_Control_out;
    logic        Mem_Control_out;
    logic [2:0]  dr, sr1, sr2, NZP;
    int checks = 0, errors = 0, cyc = 0;

    typedef struct {
        int          cyc;
        logic [15:0] alu, pc, md, ir;
        logic [1:0]  w;
        logic        m;
        logic [2:0]  dr, nzp;
    } exp_t;
    exp_t q[$];

    lc3_execute dut (
        .clock(clock), .reset(reset), .enable_execute(enable_execute),
`ifdef LC3_EXEC_FLUSH_EN
        .flush(flush),
`endif
        .IR(IR), .npc(npc), .E_Control(E_Control), .W_Control_in(W_Control_in),
        .Mem_Control_in(Mem_Control_in), .VSR1(VSR1), .VSR2(VSR2),
        .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
        .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2),
        .Mem_Bypass_Val(Mem_Bypass_Val), .aluout(aluout), .pcout(pcout),
        .W_Control_out(W_Control_out), .Mem_Control_out(Mem_Control_out),
        .M_Data(M_Data), .dr(dr), .sr1(sr1), .sr2(sr2), .NZP(NZP), .IR_Exec(IR_Exec)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " aluout"}, aluout, 16'h0);
        chk({tag, " pcout"}, pcout, 16'h0);
        chk({tag, " M_Data"}, M_Data, 16'h0);
        chk({tag, " IR_Exec"}, IR_Exec, 16'h0);
        chk({tag, " W_Control_out"}, {14'h0, W_Control_out}, 16'h0);
        chk({tag, " Mem_Control_out"}, {15'h0, Mem_Control_out}, 16'h0);
        chk({tag, " dr"}, {13'h0, dr}, 16'h0);
        chk({tag, " NZP"}, {13'h0, NZP}, 16'h0);
    endtask

    always @(negedge clock) begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("sample cycle", cyc[15:0], e.cyc[15:0]);
            chk("aluout", aluout, e.alu);
            chk("pcout", pcout, e.pc);
            chk("M_Data", M_Data, e.md);
            chk("IR_Exec", IR_Exec, e.ir);
            chk("W_Control_out", {14'h0, W_Control_out}, {14'h0, e.w});
            chk("Mem_Control_out", {15'h0, Mem_Control_out}, {15'h0, e.m});
            chk("dr", {13'h0, dr}, {13'h0, e.dr});
            chk("NZP", {13'h0, NZP}, {13'h0, e.nzp});
        end
    end

    // Called at a falling edge: drive one vector, queue its expected registered result, check sr1/sr2.
    task automatic run(input logic [15:0] ir, nv, v1, v2, mbv, input logic [5:0] ec,
                       input logic [1:0] w, input logic m, input logic [3:0] byp,
                       input logic en, fl, input logic [2:0] s1, s2,
                       input logic [15:0] ealu, epc, emd, input logic [1:0] ew,
                       input logic em, input logic [2:0] edr, enzp, input logic [15:0] eir);
        exp_t e;
        IR = ir; npc = nv; VSR1 = v1; VSR2 = v2; Mem_Bypass_Val = mbv; E_Control = ec;
        W_Control_in = w; Mem_Control_in = m; enable_execute = en; flush = fl;
        {bypass_alu_1, bypass_mem_1, bypass_alu_2, bypass_mem_2} = byp;
        e.cyc = cyc + 1; e.alu = ealu; e.pc = epc; e.md = emd; e.ir = eir;
        e.w = ew; e.m = em; e.dr = edr; e.nzp = enzp;
        q.push_back(e);
        #1;
        chk("sr1", {13'h0, sr1}, {13'h0, s1});
        chk("sr2", {13'h0, sr2}, {13'h0, s2});
        @(negedge clock);
    endtask

    initial begin
        #3 chk_zero("reset");
        @(negedge clock);
        reset = 1;
        // ADD R3,R1,#-2
        run(16'h167E, 16'h0, 16'h0005, 16'h1234, 16'h0, 6'b000000, 2'b01, 0, 4'b0000, 1, 0, 1, 6,
            16'h0003, 16'hFE83, 16'h1234, 2'b01, 0, 3, 0, 16'h167E);
        // both A bypasses: ALU bypass wins
        run(16'h1060, 16'h0, 16'h0777, 16'hABCD, 16'h00FF, 6'b000000, 2'b01, 0, 4'b1100, 1, 0, 1, 0,
            16'h0003, 16'h0063, 16'hABCD, 2'b01, 0, 0, 0, 16'h1060);
        // memory bypass on both operands
        run(16'h1060, 16'h0, 16'h0777, 16'hABCD, 16'h00FF, 6'b000000, 2'b01, 0, 4'b0101, 1, 0, 1, 0,
            16'h00FF, 16'h015F, 16'h00FF, 2'b01, 0, 0, 0, 16'h1060);
        // LEA R2,#3
        run(16'hE403, 16'h3001, 16'h0, 16'h5555, 16'h0, 6'b000110, 2'b10, 1, 4'b0000, 1, 0, 0, 3,
            16'h3004, 16'h3004, 16'h5555, 2'b10, 1, 2, 0, 16'hE403);
        // STR R5,R1,#2 with store data from own aluout
        run(16'h7A42, 16'h0, 16'h4000, 16'h9999, 16'h0, 6'b001000, 2'b00, 1, 4'b0010, 1, 0, 1, 5,
            16'h4002, 16'h4002, 16'h3004, 2'b00, 1, 5, 0, 16'h7A42);
        for (int i = 0; i < 3; i++)
            run(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'b111111, 2'b11, 0, 4'b1111, 0, 0, 7, 7,
                16'h4002, 16'h4002, 16'h3004, 2'b00, 1, 5, 0, 16'h7A42);
        // ADD wrap FFFF+1
        run(16'h1061, 16'h0, 16'hFFFF, 16'h0001, 16'h0, 6'b000000, 2'b01, 0, 4'b0000, 1, 0, 1, 1,
            16'h0000, 16'h0060, 16'h0001, 2'b01, 0, 0, 0, 16'h1061);
        // NOT R3,R1
        run(16'h967F, 16'h0, 16'h00F0, 16'h0002, 16'h0, 6'b100000, 2'b01, 0, 4'b0000, 1, 0, 1, 7,
            16'hFF0F, 16'hFF6F, 16'h0002, 2'b01, 0, 3, 0, 16'h967F);
        // reserved alu_ctl yields zero
        run(16'h167E, 16'h0, 16'h0005, 16'h0F0F, 16'h0, 6'b110000, 2'b11, 0, 4'b0000, 1, 0, 1, 6,
            16'h0000, 16'hFE83, 16'h0F0F, 2'b11, 0, 3, 0, 16'h167E);
        // JMP R7
        run(16'hC1C0, 16'h0, 16'h2000, 16'h0, 16'h0, 6'b001100, 2'b00, 0, 4'b0000, 1, 0, 7, 0,
            16'h2000, 16'h2000, 16'h0000, 2'b00, 0, 0, 3'b111, 16'hC1C0);
`ifdef LC3_EXEC_FLUSH_EN
        run(16'h167E, 16'h0, 16'h0005, 16'h0044, 16'h0, 6'b000000, 2'b01, 1, 4'b0000, 1, 1, 1, 6,
            16'h0003, 16'hFE83, 16'h0044, 2'b00, 0, 3, 0, 16'h0000);
        run(16'h167E, 16'h0, 16'h0005, 16'h0044, 16'h0, 6'b000000, 2'b01, 1, 4'b0000, 0, 1, 1, 6,
            16'h0003, 16'hFE83, 16'h0044, 2'b00, 0, 3, 0, 16'h0000);
`endif
        enable_execute = 1;
        @(posedge clock);
        #2 reset = 0;
        #1 chk_zero("async reset");
        @(negedge clock);
        chk_zero("reset held");
        reset = 1;
        // BRnp #5
        run(16'h0A05, 16'h3010, 16'h0, 16'h0, 16'h0, 6'b000110, 2'b00, 0, 4'b0000, 1, 0, 0, 5,
            16'h3015, 16'h3015, 16'h0000, 2'b00, 0, 5, 3'b101, 16'h0A05);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected results never sampled, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
